// File: rtl/mem48_dma.sv
// mem48_dma: block-transfer engine on the initiator side of a 48-bit
// single-port word memory (synchronous write, combinational read).
// Copies a run of words from src to dst, or fills a run with a constant.
//
// Ports:
//   clk, rst        rising-edge clock, synchronous active-high reset
//   start           command strobe, accepted only while idle
//   mode            0 = copy, 1 = fill
//   src, dst        source / destination word index (src unused in fill)
//   len             word count, 0..WORDS inclusive
//   fill_val        fill pattern
//   busy            high in every non-idle state
//   done            one-cycle completion pulse
//   mem_addr        memory word index
//   mem_we          memory write enable
//   mem_wdata       memory write data
//   mem_rdata       memory read data, combinational from mem_addr
module mem48_dma #(
    parameter int WORDS = 16384,
    localparam int AW = $clog2(WORDS)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          mode,
    input  logic [AW-1:0] src,
    input  logic [AW-1:0] dst,
    input  logic [AW:0]   len,
    input  logic [47:0]   fill_val,
    output logic          busy,
    output logic          done,
    output logic [AW-1:0] mem_addr,
    output logic          mem_we,
    output logic [47:0]   mem_wdata,
    input  logic [47:0]   mem_rdata
);

    localparam bit POW2 = (WORDS == (1 << AW));

    typedef enum logic [1:0] {
        IDLE,
        RD,
        WR,
        FIN
    } state_t;

    state_t        state;
    state_t        state_nx;
    logic          mode_r;
    logic [AW-1:0] src_ptr;
    logic [AW-1:0] dst_ptr;
    logic [AW:0]   count;
    logic [47:0]   hold;
    logic [47:0]   pattern;

    // Modulo-WORDS increment; power-of-two depths wrap on the natural overflow.
    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        if (!POW2 && (p == AW'(WORDS - 1)))
            return '0;
        else
            return p + AW'(1);
    endfunction

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            mode_r  <= 1'b0;
            src_ptr <= '0;
            dst_ptr <= '0;
            count   <= '0;
            hold    <= '0;
            pattern <= '0;
        end else begin
            state <= state_nx;
            case (state)
                IDLE: begin
                    if (start) begin
                        mode_r  <= mode;
                        src_ptr <= src;
                        dst_ptr <= dst;
                        count   <= len;
                        pattern <= fill_val;
                    end
                end
                RD: begin
                    hold <= mem_rdata;
                end
                WR: begin
                    count   <= count - (AW+1)'(1);
                    dst_ptr <= ptr_inc(dst_ptr);
                    if (!mode_r)
                        src_ptr <= ptr_inc(src_ptr);
                end
                default: ;
            endcase
        end
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (start) begin
                    if (len == '0)
                        state_nx = FIN;
                    else if (mode)
                        state_nx = WR;
                    else
                        state_nx = RD;
                end
            end
            RD:  state_nx = WR;
            // count still holds the pre-decrement value here
            WR: begin
                if (count == (AW+1)'(1))
                    state_nx = FIN;
                else if (mode_r)
                    state_nx = WR;
                else
                    state_nx = RD;
            end
            FIN: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Outputs decoded from state and registers
    always_comb begin
        busy      = (state != IDLE);
        done      = (state == FIN);
        mem_addr  = '0;
        mem_we    = 1'b0;
        mem_wdata = '0;
        case (state)
            RD: begin
                mem_addr = src_ptr;
            end
            WR: begin
                mem_addr  = dst_ptr;
                mem_we    = 1'b1;
                mem_wdata = mode_r ? pattern : hold;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mem48_dma.sv
// Directed bench for mem48_dma: a 16384-word instance for the main cases and
// a 16-word instance for wrap-around and full-length transfers.
module tb_mem48_dma;

    logic        clk;
    logic        rst;
    logic        start;
    logic        mode;
    logic [13:0] src;
    logic [13:0] dst;
    logic [14:0] len;
    logic [47:0] fill_val;
    logic        use_small;

    // big instance
    logic        b_busy, b_done, b_we;
    logic [13:0] b_addr;
    logic [47:0] b_wdata, b_rdata;
    // small instance
    logic        s_busy, s_done, s_we;
    logic [3:0]  s_addr;
    logic [47:0] s_wdata, s_rdata;

    logic        start_b, start_s;
    assign start_b = start & ~use_small;
    assign start_s = start & use_small;

    mem48_dma u_big (
        .clk       (clk),
        .rst       (rst),
        .start     (start_b),
        .mode      (mode),
        .src       (src),
        .dst       (dst),
        .len       (len),
        .fill_val  (fill_val),
        .busy      (b_busy),
        .done      (b_done),
        .mem_addr  (b_addr),
        .mem_we    (b_we),
        .mem_wdata (b_wdata),
        .mem_rdata (b_rdata)
    );

    mem48_dma #(.WORDS(16)) u_small (
        .clk       (clk),
        .rst       (rst),
        .start     (start_s),
        .mode      (mode),
        .src       (src[3:0]),
        .dst       (dst[3:0]),
        .len       (len[4:0]),
        .fill_val  (fill_val),
        .busy      (s_busy),
        .done      (s_done),
        .mem_addr  (s_addr),
        .mem_we    (s_we),
        .mem_wdata (s_wdata),
        .mem_rdata (s_rdata)
    );

    // Memory models with a bench-side preload port
    logic [47:0] mem_b [16384];
    logic [47:0] mem_s [16];
    logic        pre_we;
    logic [13:0] pre_a;
    logic [47:0] pre_d;

    always @(posedge clk) begin
        if (b_we)
            mem_b[b_addr] <= b_wdata;
        else if (pre_we && !use_small)
            mem_b[pre_a] <= pre_d;
        if (s_we)
            mem_s[s_addr] <= s_wdata;
        else if (pre_we && use_small)
            mem_s[pre_a[3:0]] <= pre_d;
    end
    assign b_rdata = mem_b[b_addr];
    assign s_rdata = mem_s[s_addr];

    // Observed view of whichever instance is under test
    logic        obs_busy, obs_done, obs_we;
    logic [13:0] obs_addr;
    logic [47:0] obs_wdata;
    assign obs_busy  = use_small ? s_busy  : b_busy;
    assign obs_done  = use_small ? s_done  : b_done;
    assign obs_we    = use_small ? s_we    : b_we;
    assign obs_addr  = use_small ? {10'd0, s_addr} : b_addr;
    assign obs_wdata = use_small ? s_wdata : b_wdata;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic poke(input logic [13:0] a, input logic [47:0] d);
        pre_we = 1'b1;
        pre_a  = a;
        pre_d  = d;
        @(negedge clk);
        pre_we = 1'b0;
    endtask

    // Trace of one command, cycle k = cycle T+k after the accepting edge T
    int          tr_busy, tr_done_cyc, tr_done_cnt;
    logic [13:0] tr_wa[$];
    logic [47:0] tr_wd[$];
    int          tr_wc[$];
    logic [13:0] tr_ra[$];

    task automatic run_cmd(input logic m, input logic [13:0] s, input logic [13:0] d,
                           input logic [14:0] l, input logic [47:0] fv,
                           input int budget, input bit pulse_mid);
        tr_busy = 0; tr_done_cyc = -1; tr_done_cnt = 0;
        tr_wa.delete(); tr_wd.delete(); tr_wc.delete(); tr_ra.delete();
        @(negedge clk);
        mode = m; src = s; dst = d; len = l; fill_val = fv; start = 1'b1;
        @(posedge clk);
        for (int k = 1; k <= budget; k++) begin
            @(negedge clk);
            start = pulse_mid && (k == 2);
            if (obs_busy) tr_busy++;
            if (obs_we) begin
                tr_wa.push_back(obs_addr);
                tr_wd.push_back(obs_wdata);
                tr_wc.push_back(k);
            end else if (obs_busy && !obs_done) begin
                tr_ra.push_back(obs_addr);
            end
            if (obs_done) begin
                tr_done_cnt++;
                tr_done_cyc = k;
                break;
            end
        end
        start = 1'b0;
    endtask

    task automatic idle_chk(input string tag);
        @(negedge clk);
        check_eq({tag, "_busy"},  64'(obs_busy),  64'd0);
        check_eq({tag, "_done"},  64'(obs_done),  64'd0);
        check_eq({tag, "_we"},    64'(obs_we),    64'd0);
        check_eq({tag, "_addr"},  64'(obs_addr),  64'd0);
        check_eq({tag, "_wdata"}, 64'(obs_wdata), 64'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned nwr;
        int unsigned k;
        rst = 1'b1; start = 1'b0; mode = 1'b0; src = '0; dst = '0; len = '0;
        fill_val = '0; use_small = 1'b0; pre_we = 1'b0; pre_a = '0; pre_d = '0;
        repeat (3) @(negedge clk);
        check_eq("rst_busy",  64'(b_busy),  64'd0);
        check_eq("rst_done",  64'(b_done),  64'd0);
        check_eq("rst_we",    64'(b_we),    64'd0);
        check_eq("rst_addr",  64'(b_addr),  64'd0);
        check_eq("rst_wdata", 64'(b_wdata), 64'd0);
        check_eq("rst_s_busy", 64'(s_busy), 64'd0);
        rst = 1'b0;

        // Fill 4 words at 0x010
        poke(14'h00F, 48'h0F0F_0F0F_0F0F);
        poke(14'h014, 48'h1414_1414_1414);
        run_cmd(1'b1, 14'h000, 14'h010, 15'd4, 48'hA5A5_A5A5_A5A5, 20, 1'b0);
        check_eq("fill_nwr",   64'(tr_wa.size()), 64'd4);
        for (int unsigned i = 0; i < 4; i++) begin
            check_eq("fill_addr", 64'(tr_wa[i]), 64'(14'h010 + i));
            check_eq("fill_cyc",  64'(tr_wc[i]), 64'(i + 1));
            check_eq("fill_data", 64'(tr_wd[i]), 64'hA5A5_A5A5_A5A5);
        end
        check_eq("fill_done_cyc", 64'(tr_done_cyc), 64'd5);
        check_eq("fill_busy_cyc", 64'(tr_busy), 64'd5);
        idle_chk("fill_idle");
        check_eq("fill_below", 64'(mem_b[14'h00F]), 64'h0F0F_0F0F_0F0F);
        check_eq("fill_above", 64'(mem_b[14'h014]), 64'h1414_1414_1414);
        check_eq("fill_mem2",  64'(mem_b[14'h012]), 64'hA5A5_A5A5_A5A5);

        // Copy 3 words 0x100 -> 0x200
        for (int unsigned i = 0; i < 3; i++) begin
            poke(14'h100 + 14'(i), 48'(i + 1));
            poke(14'h200 + 14'(i), 48'd0);
        end
        run_cmd(1'b0, 14'h100, 14'h200, 15'd3, 48'hDEAD, 20, 1'b0);
        check_eq("copy_nrd", 64'(tr_ra.size()), 64'd3);
        check_eq("copy_nwr", 64'(tr_wa.size()), 64'd3);
        for (int unsigned i = 0; i < 3; i++) begin
            check_eq("copy_raddr", 64'(tr_ra[i]), 64'(14'h100 + i));
            check_eq("copy_waddr", 64'(tr_wa[i]), 64'(14'h200 + i));
            check_eq("copy_wcyc",  64'(tr_wc[i]), 64'(2 * i + 2));
            check_eq("copy_wdata", 64'(tr_wd[i]), 64'(i + 1));
        end
        check_eq("copy_done_cyc", 64'(tr_done_cyc), 64'd7);
        check_eq("copy_busy_cyc", 64'(tr_busy), 64'd7);
        idle_chk("copy_idle");
        check_eq("copy_mem2", 64'(mem_b[14'h202]), 64'd3);

        // len = 0, then a back-to-back fill with a stray start mid-transfer
        run_cmd(1'b1, 14'h000, 14'h020, 15'd0, 48'h1, 10, 1'b0);
        check_eq("len0_done_cyc", 64'(tr_done_cyc), 64'd1);
        check_eq("len0_busy_cyc", 64'(tr_busy), 64'd1);
        check_eq("len0_nwr",      64'(tr_wa.size()), 64'd0);
        run_cmd(1'b1, 14'h000, 14'h030, 15'd4, 48'h5A5A, 20, 1'b1);
        check_eq("ign_nwr",      64'(tr_wa.size()), 64'd4);
        check_eq("ign_last",     64'(tr_wa[3]), 64'h033);
        check_eq("ign_done_cyc", 64'(tr_done_cyc), 64'd5);
        idle_chk("ign_idle");

        // Reset after the 3rd write of an 8-word copy
        for (int unsigned i = 0; i < 8; i++) begin
            poke(14'h300 + 14'(i), 48'h1000 + 48'(i));
            poke(14'h400 + 14'(i), 48'd0);
        end
        @(negedge clk);
        mode = 1'b0; src = 14'h300; dst = 14'h400; len = 15'd8; start = 1'b1;
        @(posedge clk);
        nwr = 0; k = 0;
        while (nwr < 3 && k < 40) begin
            @(negedge clk);
            start = 1'b0;
            k++;
            if (obs_we) nwr++;
        end
        check_eq("rmc_wr3_cyc", 64'(k), 64'd6);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_eq("rmc_busy", 64'(obs_busy), 64'd0);
        check_eq("rmc_we",   64'(obs_we),   64'd0);
        check_eq("rmc_done", 64'(obs_done), 64'd0);
        nwr = 0;
        repeat (5) begin
            @(negedge clk);
            if (obs_we || obs_done || obs_busy) nwr++;
        end
        check_eq("rmc_quiet", 64'(nwr), 64'd0);
        check_eq("rmc_w2", 64'(mem_b[14'h402]), 64'h1002);
        check_eq("rmc_w3", 64'(mem_b[14'h403]), 64'd0);
        check_eq("rmc_w7", 64'(mem_b[14'h407]), 64'd0);
        run_cmd(1'b0, 14'h305, 14'h500, 15'd2, 48'h0, 20, 1'b0);
        check_eq("rmc_re_done", 64'(tr_done_cyc), 64'd5);
        check_eq("rmc_re_w1",   64'(tr_wd[1]), 64'h1006);

        // start and rst on the same edge: command dropped
        poke(14'h600, 48'h6060);
        @(negedge clk);
        rst = 1'b1; start = 1'b1; mode = 1'b1; dst = 14'h600; len = 15'd2; fill_val = 48'hFFFF;
        @(negedge clk);
        rst = 1'b0; start = 1'b0;
        check_eq("rs_busy", 64'(obs_busy), 64'd0);
        @(negedge clk);
        check_eq("rs_busy2", 64'(obs_busy), 64'd0);
        check_eq("rs_mem",   64'(mem_b[14'h600]), 64'h6060);

        // Overlapping copy dst = src + 1 propagates word 0
        poke(14'h000, 48'd9); poke(14'h001, 48'd8);
        poke(14'h002, 48'd7); poke(14'h003, 48'd6);
        run_cmd(1'b0, 14'h000, 14'h001, 15'd3, 48'h0, 20, 1'b0);
        @(negedge clk);
        for (int unsigned i = 0; i < 4; i++)
            check_eq("ovl_mem", 64'(mem_b[i]), 64'd9);

        // 16-word instance: wrap-around copy 14,15,0,1 -> 0,1,2,3
        use_small = 1'b1;
        @(negedge clk);
        poke(14'd14, 48'hE); poke(14'd15, 48'hF);
        poke(14'd0, 48'hA0); poke(14'd1, 48'hA1);
        poke(14'd2, 48'd0);  poke(14'd3, 48'd0);
        run_cmd(1'b0, 14'd14, 14'd0, 15'd4, 48'h0, 20, 1'b0);
        check_eq("wrap_raddr0", 64'(tr_ra[0]), 64'd14);
        check_eq("wrap_raddr1", 64'(tr_ra[1]), 64'd15);
        check_eq("wrap_raddr2", 64'(tr_ra[2]), 64'd0);
        check_eq("wrap_raddr3", 64'(tr_ra[3]), 64'd1);
        for (int unsigned i = 0; i < 4; i++)
            check_eq("wrap_waddr", 64'(tr_wa[i]), 64'(i));
        // reads of 0 and 1 see the words just written from 14 and 15
        check_eq("wrap_wd2", 64'(tr_wd[2]), 64'hE);
        check_eq("wrap_wd3", 64'(tr_wd[3]), 64'hF);
        check_eq("wrap_done_cyc", 64'(tr_done_cyc), 64'd9);

        // Full-length fill of all 16 words from 5
        run_cmd(1'b1, 14'd0, 14'd5, 15'd16, 48'h1234_5678_9ABC, 40, 1'b0);
        check_eq("full_nwr", 64'(tr_wa.size()), 64'd16);
        for (int unsigned i = 0; i < 16; i++)
            check_eq("full_waddr", 64'(tr_wa[i]), 64'((i + 5) % 16));
        check_eq("full_done_cyc", 64'(tr_done_cyc), 64'd17);
        check_eq("full_busy_cyc", 64'(tr_busy), 64'd17);
        @(negedge clk);
        for (int unsigned i = 0; i < 16; i++)
            check_eq("full_mem", 64'(mem_s[i]), 64'h1234_5678_9ABC);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem48_dma.md
# mem48_dma

Block-transfer engine acting as the initiator side of the 48-bit single-port word memory interface (synchronous write, combinational read). Given a start command, it copies a run of words from a source to a destination word index, or fills a run with a constant, by driving the memory's address/write-enable/write-data and sampling its read data. It sits beside the core on the DMEM port, behind an arbiter that grants it the port while `busy` is high.

## Interface

Parameters:
- `WORDS`, 16384: memory depth in 48-bit words. Must match the attached memory.
- `AW`, derived local `$clog2(WORDS)`: address width.

Ports:
- `clk`  in  1: sole clock, rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `start`  in  1: command strobe, accepted only in IDLE.
- `mode`  in  1: 0 = copy, 1 = fill.
- `src`  in  AW: copy source word index (ignored in fill).
- `dst`  in  AW: destination word index.
- `len`  in  AW+1: word count, 0..WORDS inclusive.
- `fill_val`  in  48: fill pattern.
- `busy`  out  1: high in every non-IDLE state.
- `done`  out  1: one-cycle completion pulse.
- `mem_addr`  out  AW: memory word index.
- `mem_we`  out  1: memory write enable.
- `mem_wdata`  out  48: memory write data.
- `mem_rdata`  in  48: memory read data, combinational from `mem_addr`.

## Operation

- States: IDLE, RD, WR, FIN.
- IDLE: `start`=1 latches `mode`, `src`, `dst`, `len` and `fill_val` into internal pointers, counter and pattern register.
  - `len`=0 → FIN.
  - copy → RD.
  - fill → WR.
- `start` outside IDLE is ignored. Inputs are not sampled again until the next accepted start.
- RD (copy only): `mem_addr`=src_ptr, `mem_we`=0. At the edge, `mem_rdata` is captured into a 48-bit hold register; next state WR.
- WR: `mem_addr`=dst_ptr, `mem_we`=1, `mem_wdata`= hold (copy) or pattern (fill). At the edge:
  - count decrements.
  - dst_ptr increments; src_ptr increments in copy.
  - count reaching 0 → FIN; else copy → RD, fill → WR.
- FIN: `done`=1 for exactly this cycle; next state IDLE.
- Pointer arithmetic is modulo WORDS:
  - For power-of-two WORDS, pointers wrap naturally at AW bits.
  - Otherwise, explicit compare: WORDS-1 → 0.
- Transfer order is strictly ascending, one word fully written before the next read. Overlapping copies with dst > src therefore propagate already-written words. This is defined behaviour; software handles memmove.
- Outputs are decoded from state and registers. In IDLE and FIN: `mem_we`=0, `mem_addr`=0, `mem_wdata`=0.
- `rst` at any edge, including mid-transfer: state → IDLE; counter, pointers, hold and pattern registers → 0. Words already written stay written; no further writes occur.

## Timing

- Reset values: `busy`=0, `done`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0.
- `start` sampled at edge T; first memory access is in cycle T+1.
- Copy of N≥1 words:
  - 2N access cycles (RD,WR alternating), then FIN.
  - `busy` high for 2N+1 cycles; `done` in cycle T+2N+1.
- Fill of N≥1 words:
  - N consecutive WR cycles, then FIN.
  - `busy` high N+1 cycles; `done` in cycle T+N+1.
- `len`=0: FIN in cycle T+1; `busy` and `done` high for that one cycle; zero writes.
- A new `start` can be accepted in the cycle after FIN, so back-to-back commands have 1 idle cycle.
- `start` and `rst` at the same edge: reset wins and the command is dropped.

## Test plan

- Fill: dst=0x010, len=4, fill_val=0xA5A5_A5A5_A5A5 → `mem_we` high cycles T+1..T+4 at addresses 0x010..0x013; `done` at T+5; words 0x00F and 0x014 unchanged.
- Copy: mem[0x100..0x102]=1,2,3; src=0x100, dst=0x200, len=3 → alternating RD/WR for 6 cycles; `done` at T+7; mem[0x200..0x202]=1,2,3.
- Wrap and full length:
  - WORDS=16, copy src=14, dst=0, len=4 → reads 14,15,0,1 and writes 0,1,2,3 in order.
  - WORDS=16, fill len=16 from dst=5 → all 16 words written; `done` at T+17.
- len=0 and ignored start: `len`=0 → `busy` and `done` high only at T+1, no `mem_we`. `start` pulsed during a 4-word fill → ignored; exactly 4 writes.
- Reset mid-copy: len=8, `rst` asserted after the 3rd WR → next cycle `busy`=0, `mem_we`=0, no `done`; only 3 destination words modified; a fresh start then completes normally.
- Overlap: mem[0..3]=9,8,7,6, copy src=0, dst=1, len=3 → mem[0..3]=9,9,9,9.
